uart_loopback_top: RTL and testbench
====================================

Name: uart_loopback_top

Overview:
- Self-contained UART loopback block: an 8N1 transmitter serialises a byte onto an internal serial line, and a matching 16x-oversampling receiver on that line recovers the byte.
- Used as the system-level UART datapath check: every byte launched with tx_start must reappear on data_out before tx_done is reported.
- One shared baud-tick generator drives both halves.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate.
- OVERSAMPLE, 16, baud ticks per bit.
- DATA_BITS, 8, payload bits per frame.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- arst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk.
- data_in  input  8  byte to transmit; sampled on the cycle tx_start is high while idle.
- tx_start  input  1  transmit request (level or pulse); acted on only when the transmitter is idle.
- tx_done  output  1  one-cycle pulse at the end of the transmitted stop bit.
- rx_done  output  1  one-cycle pulse when a valid frame has been received.
- data_out  output  8  last correctly received byte; holds until the next valid frame.

Behaviour:
Baud tick generator
- BAUD_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division; the default is 651.
- Counter runs 0..BAUD_DIV-1 and wraps. It emits a one-cycle tick when the count equals BAUD_DIV-1.
- The counter free-runs from reset and is never stalled.

Transmitter
- Internal serial signal is named tx. It is registered and idles high.
- FSM states are IDLE, START, DATA, STOP.
- IDLE: on clk with tx_start=1, latch data_in into a shift register, drive tx=0 on the very next cycle, and go to START. The start bit does not wait for a tick.
- START: hold tx=0 for 16 ticks, then go to DATA.
- DATA: send 8 bits LSB first, 16 ticks each.
- STOP: drive tx=1 for 16 ticks. Then pulse tx_done for exactly one cycle and return to IDLE.
- tx_start is ignored outside IDLE, so data_in changes mid-frame have no effect.
- A tx_start held high at the return to IDLE starts a new frame on the following cycle.
- Nominal start-to-tx_done latency is 160 ticks, about 104,160 cycles. It must lie within 100,000..115,000 cycles.

Receiver
- Input is the internal tx line, passed through a 2-flop synchronizer that resets to 1.
- FSM states are IDLE, START, DATA, STOP.
- IDLE: a low synchronized line starts reception. Reset the tick counter and go to START.
- START: at tick 7 (mid-bit), re-sample the line. If it is high, treat it as a glitch and return to IDLE. If it is low, go to DATA.
- DATA: sample every 16 ticks at mid-bit, shifting LSB first, 8 samples.
- STOP: after 16 more ticks, sample the line.
  - If it is 1: load data_out from the shift register and assert rx_done on the same clock edge, so data_out is valid in the rx_done cycle. Return to IDLE.
  - If it is 0 (framing error): discard the frame. data_out is unchanged and there is no rx_done. Return to IDLE once the line goes high.
- rx_done rises about half a bit before tx_done. data_out therefore already equals the transmitted byte when tx_done rises.

Reset
- Asynchronous assertion at any time, including mid-frame, forces:
  - tx=1, tx_done=0, rx_done=0, data_out=8'h00
  - both FSMs to IDLE, all counters and shift registers to 0.
- The first tx_start after reset deassertion is accepted normally.

Test Plan:
- Reset: hold arst_n=0 for 50 ns -> tx=1, tx_done=0, rx_done=0, data_out=8'h00. No tx activity while tx_start=0.
- Single byte 8'hA5: one-cycle tx_start -> tx=0 on the next cycle. rx_done pulses once with data_out=8'hA5. tx_done rises 100,000..115,000 cycles after tx_start, with data_out=8'hA5 at that edge.
- Boundary bytes 8'h00, 8'hFF, 8'h01, 8'h80 sent back-to-back, 1.2 ms apart -> each rx_done shows the exact byte, LSB-first ordering confirmed. data_out holds between frames.
- Busy rejection: while a frame of 8'h3C is in flight, pulse tx_start with data_in=8'hC3 -> frame completes as 8'h3C, no second frame, exactly one tx_done.
- Reset mid-frame: assert arst_n low at bit 4 of 8'h5A -> outputs return to reset values immediately. A following send of 8'h96 is received correctly.
- Random regression: 100 random bytes at 1.2 ms spacing -> every rx_done has data_out equal to the byte latched at tx_start. tx_done/rx_done counts both equal 100.

Source files
------------

// File: rtl/uart_loopback_top.sv
// 8N1 UART loopback: a transmitter drives an internal serial line that a
// 16x-oversampling receiver decodes; both share one baud-tick generator.
module uart_loopback_top #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 tx_start,
  output logic                 tx_done,
  output logic                 rx_done,
  output logic [DATA_BITS-1:0] data_out
);

  localparam int BAUD_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] DIV_LAST = CW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] OS_MID   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [CW-1:0] r_baud_cnt;
  logic          w_tick;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_baud_cnt <= '0;
    end else if (r_baud_cnt == DIV_LAST) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
    end
  end

  assign w_tick = (r_baud_cnt == DIV_LAST);

  // Transmitter: start bit goes out the cycle after acceptance, not on a tick
  state_t                r_tx_state;
  logic [TW-1:0]         r_tx_tick;
  logic [BW-1:0]         r_tx_bit;
  logic [DATA_BITS-1:0]  r_tx_shift;
  logic                  r_tx;
  logic                  r_tx_done;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_tx_state <= IDLE;
      r_tx_tick  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_tx_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (tx_start) begin
            r_tx_shift <= data_in;
            r_tx       <= 1'b0;
            r_tx_tick  <= '0;
            r_tx_bit   <= '0;
            r_tx_state <= START;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_tx_tick == OS_LAST) begin
              r_tx_tick  <= '0;
              r_tx       <= r_tx_shift[0];
              r_tx_state <= DATA;
            end else begin
              r_tx_tick <= r_tx_tick + 1'b1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_tx_tick == OS_LAST) begin
              r_tx_tick  <= '0;
              r_tx_shift <= r_tx_shift >> 1;
              if (r_tx_bit == BIT_LAST) begin
                r_tx_bit   <= '0;
                r_tx       <= 1'b1;
                r_tx_state <= STOP;
              end else begin
                r_tx_bit <= r_tx_bit + 1'b1;
                r_tx     <= r_tx_shift[1];
              end
            end else begin
              r_tx_tick <= r_tx_tick + 1'b1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_tx_tick == OS_LAST) begin
              r_tx_tick  <= '0;
              r_tx_done  <= 1'b1;
              r_tx_state <= IDLE;
            end else begin
              r_tx_tick <= r_tx_tick + 1'b1;
            end
          end
        end
        default: r_tx_state <= IDLE;
      endcase
    end
  end

  logic r_sync1, r_sync2;
  logic w_rx;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= r_tx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

  // Receiver: samples mid-bit; a bad stop bit parks in STOP until the line idles
  state_t                r_rx_state;
  logic [TW-1:0]         r_rx_tick;
  logic [BW-1:0]         r_rx_bit;
  logic [DATA_BITS-1:0]  r_rx_shift;
  logic [DATA_BITS-1:0]  r_data_out;
  logic                  r_rx_done;
  logic                  r_rx_ferr;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rx_state <= IDLE;
      r_rx_tick  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_data_out <= '0;
      r_rx_done  <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_done <= 1'b0;
      case (r_rx_state)
        IDLE: begin
          if (!w_rx) begin
            r_rx_tick  <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= START;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_rx_tick == OS_MID) begin
              r_rx_tick  <= '0;
              r_rx_state <= w_rx ? IDLE : DATA;
            end else begin
              r_rx_tick <= r_rx_tick + 1'b1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_rx_tick == OS_LAST) begin
              r_rx_tick  <= '0;
              r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
              if (r_rx_bit == BIT_LAST) begin
                r_rx_bit   <= '0;
                r_rx_state <= STOP;
              end else begin
                r_rx_bit <= r_rx_bit + 1'b1;
              end
            end else begin
              r_rx_tick <= r_rx_tick + 1'b1;
            end
          end
        end
        STOP: begin
          if (r_rx_ferr) begin
            if (w_rx) begin
              r_rx_ferr  <= 1'b0;
              r_rx_state <= IDLE;
            end
          end else if (w_tick) begin
            if (r_rx_tick == OS_LAST) begin
              r_rx_tick <= '0;
              if (w_rx) begin
                r_data_out <= r_rx_shift;
                r_rx_done  <= 1'b1;
                r_rx_state <= IDLE;
              end else begin
                r_rx_ferr <= 1'b1;
              end
            end else begin
              r_rx_tick <= r_rx_tick + 1'b1;
            end
          end
        end
        default: r_rx_state <= IDLE;
      endcase
    end
  end

  assign tx_done  = r_tx_done;
  assign rx_done  = r_rx_done;
  assign data_out = r_data_out;

endmodule

// File: tb/tb_uart_loopback_top.sv
// Directed loopback bench for uart_loopback_top, run with a fast baud divider (2).
module tb_uart_loopback_top;

  localparam int CLK_FREQ   = 320_000;
  localparam int BAUD_RATE  = 10_000;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int DIV        = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int NOM_LAT    = 10 * OVERSAMPLE * DIV;
  localparam int LIMIT      = NOM_LAT + 100;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [7:0] data_in;
  logic       tx_start;
  logic       tx_done;
  logic       rx_done;
  logic [7:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_cnt   = 0;
  int tx_cnt   = 0;
  logic [7:0] rx_last = 8'h00;

  uart_loopback_top #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE), .DATA_BITS(DATA_BITS)
  ) dut (
    .clk(clk), .arst_n(arst_n), .data_in(data_in), .tx_start(tx_start),
    .tx_done(tx_done), .rx_done(rx_done), .data_out(data_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done) begin
      rx_cnt  = rx_cnt + 1;
      rx_last = data_out;
    end
    if (tx_done) tx_cnt = tx_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Launch a one-cycle tx_start and confirm the start bit appears next cycle.
  task automatic start_frame(input logic [7:0] b);
    @(negedge clk);
    data_in  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("tx_low_after_start", {31'd0, dut.r_tx}, 32'd0);
  endtask

  // Wait (bounded) for tx_done and verify the received byte is already present.
  task automatic finish_frame(input logic [7:0] b, input int rx_before, input int started_at);
    int lat;
    lat = started_at;
    while (!tx_done && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    check("tx_done_seen", {31'd0, tx_done}, 32'd1);
    check("latency_in_range",
          {31'd0, (lat >= NOM_LAT - 4) && (lat <= NOM_LAT + 4)}, 32'd1);
    check("data_out_at_tx_done", {24'd0, data_out}, {24'd0, b});
    check("one_rx_done", rx_cnt - rx_before, 32'd1);
    check("rx_byte", {24'd0, rx_last}, {24'd0, b});
  endtask

  task automatic send(input logic [7:0] b);
    int rxb;
    rxb = rx_cnt;
    start_frame(b);
    finish_frame(b, rxb, 1);
  endtask

  logic [7:0] bnd [4] = '{8'h00, 8'hFF, 8'h01, 8'h80};

  initial begin
    int txb, rxb;
    logic [7:0] rb;
    arst_n   = 1'b0;
    tx_start = 1'b0;
    data_in  = 8'h00;
    #50;
    check("rst_tx",       {31'd0, dut.r_tx}, 32'd1);
    check("rst_tx_done",  {31'd0, tx_done},  32'd0);
    check("rst_rx_done",  {31'd0, rx_done},  32'd0);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    idle(60);
    check("idle_tx_high", {31'd0, dut.r_tx}, 32'd1);
    check("idle_no_rx",   rx_cnt, 32'd0);

    send(8'hA5);
    idle(30);

    foreach (bnd[i]) begin
      send(bnd[i]);
      idle(50);
      check("data_out_holds", {24'd0, data_out}, {24'd0, bnd[i]});
    end

    // Busy rejection: a second request mid-frame must be ignored.
    txb = tx_cnt;
    rxb = rx_cnt;
    start_frame(8'h3C);
    idle(100);
    data_in  = 8'hC3;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    finish_frame(8'h3C, rxb, 102);
    idle(LIMIT);
    check("busy_one_tx_done", tx_cnt - txb, 32'd1);
    check("busy_one_rx_done", rx_cnt - rxb, 32'd1);
    check("busy_data_kept",   {24'd0, data_out}, 32'h3C);
    check("busy_line_idle",   {31'd0, dut.r_tx}, 32'd1);

    // Reset during bit 4 of 0x5A.
    start_frame(8'h5A);
    idle((OVERSAMPLE * 5 - 8) * DIV);
    #1;
    arst_n = 1'b0;
    #1;
    check("midrst_tx",       {31'd0, dut.r_tx}, 32'd1);
    check("midrst_tx_done",  {31'd0, tx_done},  32'd0);
    check("midrst_rx_done",  {31'd0, rx_done},  32'd0);
    check("midrst_data_out", {24'd0, data_out}, 32'd0);
    idle(3);
    arst_n = 1'b1;
    idle(5);
    send(8'h96);
    idle(20);

    txb = tx_cnt;
    rxb = rx_cnt;
    for (int k = 0; k < 100; k++) begin
      rb = 8'($urandom_range(0, 255));
      send(rb);
      idle(10);
    end
    check("rand_tx_count", tx_cnt - txb, 32'd100);
    check("rand_rx_count", rx_cnt - rxb, 32'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
